// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the Game-of-Life row engine.
//   HSUM_W / NSUM_W : widths of a 3-cell horizontal sum and a full neighbour count
//   state_t         : row sequencer states
//   CONWAY_*        : default B3/S23 rule masks (bit n = neighbour count n)
package life_pkg;

    localparam int HSUM_W = 2;
    localparam int NSUM_W = 4;

    localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
    localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/life_rule.sv
// life_rule: combinational single-cell Life rule.
// Ports:
//   alive : current state of the cell
//   n     : live neighbour count (0..8)
//   next  : next-generation state
// Parameters BIRTH / SURVIVE: bit n set enables birth / survival at count n.
module life_rule
    import life_pkg::*;
#(
    parameter logic [8:0] BIRTH   = CONWAY_BIRTH,
    parameter logic [8:0] SURVIVE = CONWAY_SURVIVE
) (
    input  logic              alive,
    input  logic [NSUM_W-1:0] n,
    output logic              next
);

    always_comb begin
        next = 1'b0;
        // Counts above 8 cannot occur with legal sums; treat them as dead.
        if (n <= NSUM_W'(8)) begin
            next = alive ? SURVIVE[n] : BIRTH[n];
        end
    end

endmodule

// File: rtl/life_row_engine.sv
// life_row_engine: one grid row of a lockstep Game-of-Life array.
// Accepts LANES cells per beat, keeps a (LANES+2)-cell window spanning beat
// boundaries, exports per-cell horizontal sums and computes the next generation
// from its window plus the sums of the rows above (nsum_a) and below (nsum_b).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input beat handshake (in_ready low only in FLUSH)
//   in_cells            : current-row cells, bit i = column beat*LANES+i
//   nsum_a / nsum_b     : 2-bit per-lane sums from neighbour rows, same cycle
//   out_valid/out_last  : output beat pulse / final beat of the row
//   out_cells           : next-generation cells
//   out_hsum            : 2-bit per-lane horizontal sums of current generation
//   out_pop             : row live count (only with LIFE_POP_COUNT_EN defined)
// Optional feature macro: LIFE_POP_COUNT_EN
module life_row_engine
    import life_pkg::*;
#(
    parameter int         LANES   = 4,
    parameter int         ROW_LEN = 64,
    parameter logic [8:0] BIRTH   = CONWAY_BIRTH,
    parameter logic [8:0] SURVIVE = CONWAY_SURVIVE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0]             in_cells,
    input  logic [2*LANES-1:0]           nsum_a,
    input  logic [2*LANES-1:0]           nsum_b,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [LANES-1:0]             out_cells,
    output logic [2*LANES-1:0]           out_hsum
`ifdef LIFE_POP_COUNT_EN
    ,
    output logic [$clog2(ROW_LEN+1)-1:0] out_pop
`endif
);

    localparam int NB    = ROW_LEN / LANES;
    localparam int COL_W = (NB > 1) ? $clog2(NB) : 1;

    state_t           r_state, w_state_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [LANES-1:0] r_p, w_p_nxt;
    logic             r_pmsb, w_pmsb_nxt;
    logic [LANES+1:0] r_win, w_win_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_last, w_last_nxt;
    logic             w_accept;
    logic [LANES-1:0] w_next;

    assign in_ready = (r_state != FLUSH);
    assign w_accept = in_valid && in_ready;

    // The window lags the input by one beat: a beat is only evaluated once the
    // following beat (or the dead right edge in FLUSH) supplies its right neighbour.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_p_nxt     = r_p;
        w_pmsb_nxt  = r_pmsb;
        w_win_nxt   = r_win;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_p_nxt     = in_cells;
                    w_pmsb_nxt  = 1'b0;
                    w_col_nxt   = COL_W'((NB > 1) ? 1 : 0);
                    w_state_nxt = (NB == 1) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (w_accept) begin
                    w_win_nxt   = {in_cells[0], r_p, r_pmsb};
                    w_pmsb_nxt  = r_p[LANES-1];
                    w_p_nxt     = in_cells;
                    w_valid_nxt = 1'b1;
                    if (r_col == COL_W'(NB - 1)) begin
                        w_col_nxt   = '0;
                        w_state_nxt = FLUSH;
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end
            end
            FLUSH: begin
                w_win_nxt   = {1'b0, r_p, r_pmsb};
                w_valid_nxt = 1'b1;
                w_last_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_p     <= '0;
            r_pmsb  <= 1'b0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_p     <= w_p_nxt;
            r_pmsb  <= w_pmsb_nxt;
            r_win   <= w_win_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign out_valid = r_valid;
    assign out_last  = r_last;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [NSUM_W-1:0] w_n;

        assign out_hsum[2*i +: 2] = HSUM_W'({1'b0, r_win[i]})
                                  + HSUM_W'({1'b0, r_win[i+1]})
                                  + HSUM_W'({1'b0, r_win[i+2]});

        // Vertical neighbours arrive pre-summed; only the left/right cells of
        // this row are added here (the centre cell is not its own neighbour).
        assign w_n = NSUM_W'(nsum_a[2*i +: 2])
                   + NSUM_W'(nsum_b[2*i +: 2])
                   + NSUM_W'(r_win[i])
                   + NSUM_W'(r_win[i+2]);

        life_rule #(
            .BIRTH   (BIRTH),
            .SURVIVE (SURVIVE)
        ) u_rule (
            .alive (r_win[i+1]),
            .n     (w_n),
            .next  (w_next[i])
        );

        assign out_cells[i] = r_valid & w_next[i];
    end

`ifdef LIFE_POP_COUNT_EN
    localparam int POP_W = $clog2(ROW_LEN + 1);

    logic [POP_W-1:0] r_acc;
    logic [POP_W-1:0] w_beat_pop;

    always_comb begin
        w_beat_pop = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_beat_pop = w_beat_pop + POP_W'(out_cells[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_last) begin
            r_acc <= '0;
        end else if (r_valid) begin
            r_acc <= r_acc + w_beat_pop;
        end
    end

    // Includes the beat on display so the out_last cycle shows the full row total.
    assign out_pop = r_acc + w_beat_pop;
`endif

endmodule

// File: tb/tb_life_row_engine.sv
// tb_life_row_engine: directed bench for life_row_engine (LANES=4, ROW_LEN=8).
// A row-level reference model computes expected outputs per beat; a compare
// process checks every output cycle and drives nsum_a/nsum_b for the beat due.
// Honours LIFE_POP_COUNT_EN (connects and checks out_pop when defined).
module tb_life_row_engine;

    localparam int LANES   = 4;
    localparam int ROW_LEN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_cells = '0;
    logic [7:0] nsum_a = '0;
    logic [7:0] nsum_b = '0;
    logic       out_valid;
    logic       out_last;
    logic [3:0] out_cells;
    logic [7:0] out_hsum;
`ifdef LIFE_POP_COUNT_EN
    logic [3:0] out_pop;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] na;
        logic [7:0] nb;
        logic [3:0] cells;
        logic [7:0] hsum;
        logic       last;
        int         pop;
    } exp_t;

    exp_t expq[$];

    life_row_engine #(
        .LANES   (LANES),
        .ROW_LEN (ROW_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cells  (in_cells),
        .nsum_a    (nsum_a),
        .nsum_b    (nsum_b),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_cells (out_cells),
        .out_hsum  (out_hsum)
`ifdef LIFE_POP_COUNT_EN
        ,
        .out_pop   (out_pop)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Horizontal 3-cell sums of a whole row, dead outside columns 0..7.
    function automatic logic [15:0] row_hsum(input logic [7:0] row);
        logic [9:0]  pad;
        logic [15:0] h;
        pad = {1'b0, row, 1'b0};
        h   = '0;
        for (int c = 0; c < 8; c++) begin
            h[2*c +: 2] = 2'(int'(pad[c]) + int'(pad[c+1]) + int'(pad[c+2]));
        end
        return h;
    endfunction

    // Reference model: Conway B3/S23 applied to a whole row.
    task automatic push_row(input logic [7:0] row, input logic [15:0] na, input logic [15:0] nb);
        logic [9:0] pad;
        int         pop;
        pad = {1'b0, row, 1'b0};
        pop = 0;
        for (int b = 0; b < 2; b++) begin
            exp_t e;
            e.cells = '0;
            e.hsum  = '0;
            for (int i = 0; i < 4; i++) begin
                int c, l, me, r, n;
                logic nxt;
                c  = b*4 + i;
                l  = int'(pad[c]);
                me = int'(pad[c+1]);
                r  = int'(pad[c+2]);
                n  = int'(na[2*c +: 2]) + int'(nb[2*c +: 2]) + l + r;
                nxt = (me != 0) ? (n == 2 || n == 3) : (n == 3);
                e.cells[i]      = nxt;
                e.hsum[2*i +: 2] = 2'(l + me + r);
                pop += int'(nxt);
            end
            e.na   = na[8*b +: 8];
            e.nb   = nb[8*b +: 8];
            e.last = (b == 1);
            e.pop  = pop;
            expq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("out_cells", out_cells, e.cells);
                chk("out_hsum", out_hsum, e.hsum);
                chk("out_last", out_last, e.last);
`ifdef LIFE_POP_COUNT_EN
                chk("out_pop", out_pop, e.pop);
`endif
            end
        end else begin
            chk("quiet_cells", out_cells, 0);
            chk("quiet_last", out_last, 0);
        end
        if (expq.size() > 0) begin
            nsum_a = expq[0].na;
            nsum_b = expq[0].nb;
        end else begin
            nsum_a = '0;
            nsum_b = '0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_cells", out_cells, 0);
        chk("rst_out_hsum", out_hsum, 0);
        chk("rst_out_last", out_last, 0);
`ifdef LIFE_POP_COUNT_EN
        chk("rst_out_pop", out_pop, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [3:0] c, input logic exp_ov, input string nm);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_cells = c;
        while (!in_ready && g < 8) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_cells = '0;
        chk({nm, "_out_valid"}, out_valid, exp_ov);
        @(negedge clk);
    endtask

    task automatic send_row(input logic [7:0] row, input logic [15:0] na,
                            input logic [15:0] nb, input int gap);
        push_row(row, na, nb);
        send_beat(row[3:0], 1'b0, "beat0");
        repeat (gap) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", out_valid, 0);
            @(negedge clk);
        end
        send_beat(row[7:4], 1'b1, "beat1");
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("post_flush_in_ready", in_ready, 1);
        chk("flush_out_last", out_last, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();

        // In-beat blinker
        send_row(8'b0000_0111, '0, '0, 0);
        // Pins checked on the first beat of that row via its queue entry would
        // already be consumed; re-derive from a fresh model push instead.
        push_row(8'b0000_0111, '0, '0);
        n = expq.size();
        chk("pin_blinker_hsum", expq[n-2].hsum, 8'h6E);
        chk("pin_blinker_cells", expq[n-2].cells, 4'b0010);
        void'(expq.pop_back());
        void'(expq.pop_back());

        // Cross-beat neighbours
        push_row(8'b0001_1000, '0, '0);
        n = expq.size();
        chk("pin_cross_b0_lane3", expq[n-2].hsum[7:6], 2);
        chk("pin_cross_b1_lane0", expq[n-1].hsum[1:0], 2);
        chk("pin_cross_cells", {expq[n-1].cells, expq[n-2].cells}, 0);
        void'(expq.pop_back());
        void'(expq.pop_back());
        send_row(8'b0001_1000, '0, '0, 0);

        // Birth from neighbour rows: col1 gets 1 from above, 2 from below
        push_row(8'h00, 16'h0004, 16'h0008);
        n = expq.size();
        chk("pin_birth_cells", expq[n-2].cells, 4'b0010);
        void'(expq.pop_back());
        void'(expq.pop_back());
        send_row(8'h00, 16'h0004, 16'h0008, 0);

        // Stall: in_valid 1,0,0,1
        send_row(8'b0110_1101, 16'h5A5A, 16'h1234, 2);

        // Back-to-back rows
        send_row(8'hFF, 16'hFFFF, 16'h0000, 0);
        send_row(8'b1010_0101, 16'h0F0F, 16'hF0F0, 0);

        // Reset mid-row, then realigned row with the row above identical
        send_beat(4'b1111, 1'b0, "abort_beat0");
        do_reset();
        chk("abort_queue_empty", expq.size(), 0);
        push_row(8'b1110_0111, row_hsum(8'b1110_0111), '0);
        n = expq.size();
        chk("pin_pop_total", expq[n-1].pop, 4);
        void'(expq.pop_back());
        void'(expq.pop_back());
        send_row(8'b1110_0111, row_hsum(8'b1110_0111), '0, 1);

        n = 0;
        while (expq.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outputs", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_row_engine.md
# life_row_engine

Multi-lane, parametrised Game-of-Life row processor. Each instance owns one grid row. It accepts LANES cells per beat and keeps a beat window so neighbours are seen across beat boundaries. It exports a 3-cell horizontal sum for each cell so the rows above and below can use it, and it computes the next generation from its own window plus the sums received from those two neighbour rows. Instances are stacked one per row and all share in_valid, so the whole array advances in lockstep.

## Interface
- LANES, 4: cells per beat; must be 1 or greater.
- ROW_LEN, 64: cells per row; must be a multiple of LANES. NB = ROW_LEN/LANES beats per row.
- BIRTH, 9'b000001000: bit n set means a dead cell with n neighbours becomes live.
- SURVIVE, 9'b000001100: bit n set means a live cell with n neighbours stays live.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat present on in_cells.
- in_ready  out  1  engine accepts a beat; a beat transfers when in_valid and in_ready are both high.
- in_cells  in  LANES  current-row cells; bit i = column beat*LANES+i.
- nsum_a  in  2*LANES  per-lane horizontal sums (0..3) from the row above.
- nsum_b  in  2*LANES  per-lane horizontal sums (0..3) from the row below.
- out_valid  out  1  one-cycle pulse per produced output beat.
- out_last  out  1  high with the final beat of a row.
- out_cells  out  LANES  next-generation cells.
- out_hsum  out  2*LANES  per-lane horizontal sum of the current generation.
- out_pop  out  $clog2(ROW_LEN+1)  live count for the row; present only with LIFE_POP_COUNT_EN.

## Operation
- Registers:
  - P (LANES bits): last accepted beat.
  - pmsb: bit LANES-1 of the previous P.
  - win (LANES+2 bits): win[0] is the left neighbour, win[1..LANES] the centre beat, win[LANES+1] the right neighbour.
  - col: beat counter, 0..NB-1.
- States:
  - IDLE: waiting for beat 0. On accept: P<=in_cells, pmsb<=0. Go to FLUSH if NB==1, else RUN.
  - RUN: on accept of beat j: win<={in_cells[0], P, pmsb}, pmsb<=P[LANES-1], P<=in_cells, out_valid<=1. Go to FLUSH when j==NB-1.
  - FLUSH: in_ready=0 for exactly one cycle. win<={1'b0, P, pmsb}, out_valid<=1, out_last<=1, then go to IDLE.
- Row edges are dead: column -1 and column ROW_LEN read as 0.
- in_ready = (state != FLUSH). It is combinational from state only.
- Per lane i:
  - out_hsum[i] = win[i]+win[i+1]+win[i+2], 2 bits.
  - n = nsum_a[i]+nsum_b[i]+win[i]+win[i+2], 4 bits, range 0..8.
  - out_cells[i] = out_valid & (win[i+1] ? SURVIVE[n] : BIRTH[n]).
- nsum_a and nsum_b are consumed combinationally in the cycle out_valid is high. They must come from neighbour out_hsum in the same cycle.
- Grid edges (no row above or below) tie the corresponding nsum to 0.
- Reset, including mid-row:
  - state=IDLE, col=0, P=0, pmsb=0, win=0.
  - out_valid=0, out_last=0, out_cells=0, out_hsum=0, in_ready=1, out_pop=0.
  - The partial row is discarded; the next accepted beat is column 0.

## Timing
- Output beat k is presented one cycle after input beat k+1 is accepted.
- The last output beat of a row is presented one cycle after the FLUSH cycle.
- A row of NB beats produces NB out_valid pulses; the final one carries out_last.
- Gaps in in_valid stall the engine. No output is produced while stalled, and window contents are held.
- The next row's beat 0 can be accepted in the cycle right after FLUSH.
- Minimum row period is NB+1 cycles.

## Configuration
- LIFE_POP_COUNT_EN defined:
  - Adds the out_pop port and an accumulator.
  - On each out_valid the accumulator adds popcount(out_cells).
  - out_pop shows the row total in the out_last cycle and the running partial sum otherwise.
  - The accumulator clears on the cycle after out_last and on rst.
- LIFE_POP_COUNT_EN undefined: no port and no logic.

## Structure
- life_pkg holds:
  - HSUM_W=2 and NSUM_W=4.
  - the state enum (IDLE, RUN, FLUSH).
  - CONWAY_BIRTH and CONWAY_SURVIVE default masks.
- Sub-module life_rule: combinational cell rule taking alive, n[3:0], BIRTH and SURVIVE, producing next. It is instantiated LANES times in a generate loop.

## Test plan
All scenarios use LANES=4, ROW_LEN=8.
- Reset: hold rst 2 cycles → out_valid=0, in_ready=1, out_cells=0, out_hsum=0.
- In-beat blinker: beat0=4'b0111, beat1=0, nsums 0 → first output has out_hsum lanes0..3 = 2,3,2,1 and out_cells=4'b0010.
- Cross-beat neighbours: beat0=4'b1000, beat1=4'b0001 → beat0 lane3 hsum=2, beat1 lane0 hsum=2, all out_cells=0.
- Birth from neighbours: in_cells all 0, beat0 nsum_a lane1=1, nsum_b lane1=2 → out_cells beat0=4'b0010.
- Stall/flush: in_valid pattern 1,0,0,1 → first out_valid the cycle after beat1 is accepted; in_ready low exactly one cycle; second out_valid carries out_last.
- Reset mid-row plus pop count: assert rst after beat0, then stream row beat0=4'b0111, beat1=4'b1110 → rows realign, out_pop=4 with out_last (LIFE_POP_COUNT_EN defined).
